// File: rtl/mlp_acc_tree.sv
// Neuron summation stage: a pipelined sign-magnitude adder tree feeding a multi-beat
// accumulator, with a saturating sign-magnitude output register.
module mlp_acc_tree #(
    parameter int N_IN  = 8,
    parameter int IN_W  = 15,
    parameter int OUT_W = 21,
    parameter int ACC_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_first,
    input  logic                 in_last,
    input  logic [N_IN*IN_W-1:0] in_data,
    input  logic [IN_W-1:0]      bias,
    output logic                 out_valid,
    output logic [OUT_W-1:0]     out_data,
    output logic                 out_ovf,
    output logic                 err,
    output logic                 dbg_state
);
    localparam int LVL   = $clog2(N_IN);
    localparam int NODES = 2 * N_IN - 1;
    localparam logic [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};

    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

    function automatic logic [ACC_W-1:0] sm_to_tc(input logic [IN_W-1:0] x);
        logic [ACC_W-1:0] mag;
        mag = {{(ACC_W-IN_W+1){1'b0}}, x[IN_W-2:0]};
        return x[IN_W-1] ? -mag : mag;
    endfunction

    // Heap-ordered tree: leaves at N_IN-1.., node k sums children 2k+1 and 2k+2, root is node 0.
    logic [ACC_W-1:0] tree_q [NODES];
    logic [LVL:0]     sb_v_q, sb_f_q, sb_l_q;
    logic [ACC_W-1:0] sb_bias_q [LVL+1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < NODES; n++) tree_q[n] <= '0;
        end else begin
            for (int k = 0; k < N_IN - 1; k++) tree_q[k] <= tree_q[2*k+1] + tree_q[2*k+2];
            for (int i = 0; i < N_IN; i++) tree_q[N_IN-1+i] <= sm_to_tc(in_data[i*IN_W +: IN_W]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_v_q <= '0;
            sb_f_q <= '0;
            sb_l_q <= '0;
            for (int j = 0; j <= LVL; j++) sb_bias_q[j] <= '0;
        end else begin
            sb_v_q       <= {sb_v_q[LVL-1:0], in_valid};
            sb_f_q       <= {sb_f_q[LVL-1:0], in_first};
            sb_l_q       <= {sb_l_q[LVL-1:0], in_last};
            sb_bias_q[0] <= sm_to_tc(bias);
            for (int j = 1; j <= LVL; j++) sb_bias_q[j] <= sb_bias_q[j-1];
        end
    end

    logic             beat_v, beat_f, beat_l;
    logic [ACC_W-1:0] beat_sum, beat_bias;

    assign beat_v    = sb_v_q[LVL];
    assign beat_f    = sb_f_q[LVL];
    assign beat_l    = sb_l_q[LVL];
    assign beat_sum  = tree_q[0];
    assign beat_bias = sb_bias_q[LVL];

    state_t state_q, state_d;
    logic   acc_load, acc_add, fin, proto_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (beat_v) begin
            if (beat_f)                         state_d = beat_l ? IDLE : ACCUM;
            else if (state_q == ACCUM && beat_l) state_d = IDLE;
        end
    end

    // A first beat always restarts; a non-first beat outside a vector is dropped.
    always_comb begin
        acc_load  = 1'b0;
        acc_add   = 1'b0;
        fin       = 1'b0;
        proto_err = 1'b0;
        if (beat_v) begin
            case (state_q)
                IDLE: begin
                    if (beat_f) begin
                        acc_load = 1'b1;
                        fin      = beat_l;
                    end else begin
                        proto_err = 1'b1;
                    end
                end
                ACCUM: begin
                    acc_load  = beat_f;
                    proto_err = beat_f;
                    acc_add   = ~beat_f;
                    fin       = beat_l;
                end
                default: ;
            endcase
        end
    end

    assign dbg_state = state_q;

    logic [ACC_W-1:0] acc_q;
    logic             done_q, err_pend_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= '0;
            done_q     <= 1'b0;
            err_pend_q <= 1'b0;
        end else begin
            if (acc_load)     acc_q <= beat_sum + beat_bias;
            else if (acc_add) acc_q <= acc_q + beat_sum;
            done_q     <= fin;
            err_pend_q <= proto_err;
        end
    end

    logic             acc_neg, sat;
    logic [ACC_W-1:0] acc_mag;
    logic [OUT_W-2:0] mag_sat;

    assign acc_neg = acc_q[ACC_W-1];
    assign acc_mag = acc_neg ? -acc_q : acc_q;
    assign sat     = acc_mag > SAT_MAX;
    assign mag_sat = sat ? {(OUT_W-1){1'b1}} : acc_mag[OUT_W-2:0];

    logic             cv_valid_q, cv_ovf_q, err_q;
    logic [OUT_W-1:0] cv_data_q;
    logic             out_valid_q, out_ovf_q;
    logic [OUT_W-1:0] out_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cv_valid_q  <= 1'b0;
            cv_data_q   <= '0;
            cv_ovf_q    <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            cv_valid_q  <= done_q;
            err_q       <= err_pend_q;
            if (done_q) begin
                cv_data_q <= {acc_neg, mag_sat};
                cv_ovf_q  <= sat;
            end
            out_valid_q <= cv_valid_q;
            if (cv_valid_q) begin
                out_data_q <= cv_data_q;
                out_ovf_q  <= cv_ovf_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign err       = err_q;
endmodule

// File: doc/mlp_acc_tree.md
# mlp_acc_tree

Pipelined, parametrised sign-magnitude adder tree with a multi-beat accumulator. It is the neuron summation stage: it sums N_IN products per beat plus a bias and accumulates across beats, so a neuron with more inputs than lanes is reduced over several cycles. The result is emitted as a saturated sign-magnitude word to the activation stage.

## Interface
- N_IN, 8: lanes per beat; power of two, ≥2
- IN_W, 15: input/bias width; sign-magnitude (MSB sign, IN_W-1 magnitude bits)
- OUT_W, 21: output width; sign-magnitude
- ACC_W, 32: internal two's-complement width; must be ≥ OUT_W+1 and ≥ IN_W+log2(N_IN)+1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  beat present
- in_first  in  1  first beat of a vector; qualified by in_valid
- in_last  in  1  last beat of a vector; qualified by in_valid
- in_data  in  N_IN*IN_W  lane i at bits [i*IN_W +: IN_W]
- bias  in  IN_W  sampled only on a first beat
- out_valid  out  1  one-cycle result strobe
- out_data  out  OUT_W  sign-magnitude sum; valid with out_valid
- out_ovf  out  1  result saturated; valid with out_valid
- err  out  1  one-cycle protocol-error pulse

## Operation
- Stage 0 registers the inputs and converts each lane and the bias to ACC_W two's complement. -0 converts to 0.
- Stages 1..log2(N_IN) each hold one registered tree level of pairwise adds. in_valid, in_first, in_last and the converted bias travel alongside the data.
- Accumulate stage FSM with states IDLE and ACCUM:
  - IDLE, valid first beat: acc = tree_sum + bias. Go to ACCUM, or stay in IDLE if the beat is also last.
  - ACCUM, valid non-first beat: acc += tree_sum. Return to IDLE on a last beat.
  - IDLE, valid non-first beat: beat dropped, err pulses, no state change.
  - ACCUM, valid first beat: partial sum discarded, restart with the new beat, err pulses.
  - A single-beat vector sets first and last together.
  - Bubbles (in_valid=0) mid-vector are allowed. acc holds.
- Output stage runs on a completed last beat:
  - Converts acc to sign-magnitude.
  - If |acc| > 2^(OUT_W-1)-1, magnitude saturates to all ones, sign is kept, and out_ovf=1.
  - A zero result always has sign 0.
- No backpressure. Downstream must accept out_valid every cycle.
- The caller guarantees that ACC_W does not overflow. Behaviour on ACC_W overflow is unspecified.

## Timing
- LAT = log2(N_IN) + 3 edges (6 for N_IN=8). The sampling edge counts as edge 0.
- out_valid is high for exactly one cycle, beginning after edge LAT counted from the edge that samples the last beat.
- err is high for one cycle, beginning after edge log2(N_IN)+2 counted from the offending beat.
- Throughput: one beat per cycle. A new in_first may follow an in_last on the next cycle with no gap.
- Reset values: out_valid=0, out_data=0, out_ovf=0, err=0. All pipeline valids are cleared, acc=0, FSM=IDLE.
- Reset mid-vector or mid-pipeline: all in-flight beats and the partial sum are lost. No out_valid is issued for them. The first valid beat after reset must be a first beat, otherwise err pulses.
- out_data and out_ovf hold their last values while out_valid=0.

## Test plan
Default parameters, 15-bit sign-magnitude hex:
- **Single beat:** all lanes 0x0064 (+100), bias 0x0005, first=last=1 -> after 6 edges out_valid=1, out_data=805 (0x000325), out_ovf=0.
- **Negative zero and cancellation:**
  - All lanes 0x4000 (-0), bias 0 -> out_data=0x000000 (sign 0).
  - Lanes alternating +1000/-1000 (0x03E8/0x43E8), bias 0x4003 -> out_data=-3 (0x100003).
- **Multi-beat with bubble:** three beats of all lanes 0x3FFF, bias 0x4001 (-1), one idle cycle between beats 2 and 3 -> single out_valid with out_data=393191 (0x05FFE7).
- **Saturation:**
  - Ten beats of all lanes +16383 -> out_data=0x0FFFFF, out_ovf=1.
  - Same with all lanes 0x7FFF -> out_data=0x1FFFFF, out_ovf=1.
- **Back-to-back and protocol errors:**
  - Vector A (1 beat, sum 8) then vector B (1 beat, sum 16) on consecutive cycles -> out_valid on consecutive cycles with 8 then 16.
  - Non-first beat while IDLE -> err pulse, no out_valid.
  - in_first during ACCUM -> err pulse, result reflects only the new vector.
- **Reset mid-operation:** assert rst for 1 cycle between beat 2 and beat 3 of a 3-beat vector -> no out_valid. A following clean single-beat vector with lanes +1 and bias 0 yields out_data=8.
